// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg : next-PC select codes and fetch state encoding shared with controller
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] PC_PLUS   = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_LABEL  = 2'd2;
  localparam logic [1:0] PC_RM     = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam int LABEL_W = 11;

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
// -----------------------------------------------------------------------------
// pc_next_mux : combinational next-PC selection (increment, branch, label, Rm)
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int LENGTH = 16
) (
  input  logic [1:0]        pc_sel_i,
  input  logic [LENGTH-1:0] pc_i,
  input  logic [LENGTH-1:0] ir_i,
  input  logic [LENGTH-1:0] branch_target_i,
  input  logic [LENGTH-1:0] rm_value_i,
  output logic [LENGTH-1:0] next_pc_o
);

  always_comb begin
    // Increment wraps naturally at 2^LENGTH.
    next_pc_o = pc_i + LENGTH'(1);
    case (pc_sel_i)
      PC_PLUS:   next_pc_o = pc_i + LENGTH'(1);
      PC_BRANCH: next_pc_o = branch_target_i;
      PC_LABEL:  next_pc_o = LENGTH'(ir_i[LABEL_W-1:0]);
      PC_RM:     next_pc_o = rm_value_i;
      default:   next_pc_o = pc_i + LENGTH'(1);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit : RESET/FETCH/EXEC/HALT instruction fetch with IR decode.
// Optional retire counter enabled by macro IFETCH_RETIRE_COUNT_EN.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int                LENGTH   = 16,
  parameter logic [LENGTH-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imemReq,
  output logic [LENGTH-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [LENGTH-1:0] imemData,
  input  logic [1:0]        pcSel,
  input  logic              hlt,
  input  logic [LENGTH-1:0] branchTarget,
  input  logic [LENGTH-1:0] rmValue,
  output logic              instrValid,
  output logic [4:0]        opcode,
  output logic [1:0]        branchFunc,
  output logic [1:0]        functionCode,
  output logic [2:0]        rd,
  output logic [2:0]        rm,
  output logic [2:0]        rn,
  output logic [7:0]        imm8,
  output logic [LENGTH-1:0] pc,
  output logic [LENGTH-1:0] pcPlus1,
  output logic              halted
`ifdef IFETCH_RETIRE_COUNT_EN
  ,
  output logic [LENGTH-1:0] retireCnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [LENGTH-1:0] pc_q, pc_d;
  logic [LENGTH-1:0] ir_q, ir_d;
  logic [LENGTH-1:0] next_pc;

  pc_next_mux #(
    .LENGTH (LENGTH)
  ) u_pc_next_mux (
    .pc_sel_i        (pcSel),
    .pc_i            (pc_q),
    .ir_i            (ir_q),
    .branch_target_i (branchTarget),
    .rm_value_i      (rmValue),
    .next_pc_o       (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imemAck) begin
          ir_d    = imemData;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Halt freezes pc whatever the controller selects.
        if (hlt) begin
          state_d = ST_HALT;
        end else begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef IFETCH_RETIRE_COUNT_EN
  logic [LENGTH-1:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (state_q == ST_EXEC && retire_q != '1) begin
      retire_d = retire_q + LENGTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retireCnt = retire_q;
`endif

  assign imemReq      = (state_q == ST_FETCH);
  assign instrValid   = (state_q == ST_EXEC);
  assign halted       = (state_q == ST_HALT);
  assign imemAddr     = pc_q;
  assign pc           = pc_q;
  assign pcPlus1      = pc_q + LENGTH'(1);
  assign opcode       = ir_q[15:11];
  assign branchFunc   = ir_q[9:8];
  assign functionCode = ir_q[1:0];
  assign rd           = ir_q[10:8];
  assign rm           = ir_q[7:5];
  assign rn           = ir_q[4:2];
  assign imm8         = ir_q[7:0];

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit : directed and random stimulus against a cycle-level model
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_ifetch_unit;

  localparam int          LENGTH   = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [15:0] imemData = '0;
  logic [1:0]  pcSel = '0;
  logic        hlt = 1'b0;
  logic [15:0] branchTarget = '0;
  logic [15:0] rmValue = '0;
  logic        instrValid;
  logic [4:0]  opcode;
  logic [1:0]  branchFunc;
  logic [1:0]  functionCode;
  logic [2:0]  rd, rm, rn;
  logic [7:0]  imm8;
  logic [15:0] pc, pcPlus1;
  logic        halted;
`ifdef IFETCH_RETIRE_COUNT_EN
  logic [15:0] retireCnt;
`endif

  ifetch_unit #(.LENGTH(LENGTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemAck      (imemAck),
    .imemData     (imemData),
    .pcSel        (pcSel),
    .hlt          (hlt),
    .branchTarget (branchTarget),
    .rmValue      (rmValue),
    .instrValid   (instrValid),
    .opcode       (opcode),
    .branchFunc   (branchFunc),
    .functionCode (functionCode),
    .rd           (rd),
    .rm           (rm),
    .rn           (rn),
    .imm8         (imm8),
    .pc           (pc),
    .pcPlus1      (pcPlus1),
    .halted       (halted)
`ifdef IFETCH_RETIRE_COUNT_EN
    ,
    .retireCnt    (retireCnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: phase of the instruction cycle, architectural pc, fetched word, retires.
  localparam int M_RESET = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;
  int          m_phase;
  logic [15:0] m_pc, m_ir, m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [15:0] model_next(input logic [1:0] sel, input logic [15:0] p,
                                             input logic [15:0] ir, input logic [15:0] bt,
                                             input logic [15:0] rmv);
    case (sel)
      2'd0:    return 16'((32'(p) + 1) % 65536);
      2'd1:    return bt;
      2'd2:    return ir & 16'h07FF;
      default: return rmv;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= M_RESET;
      m_pc    <= RESET_PC;
      m_ir    <= '0;
      m_cnt   <= '0;
    end else if (m_phase == M_RESET) begin
      m_phase <= M_FETCH;
    end else if (m_phase == M_FETCH) begin
      if (imemAck) begin
        m_ir    <= imemData;
        m_phase <= M_EXEC;
      end
    end else if (m_phase == M_EXEC) begin
      if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      if (hlt) begin
        m_phase <= M_HALT;
      end else begin
        m_pc    <= model_next(pcSel, m_pc, m_ir, branchTarget, rmValue);
        m_phase <= M_FETCH;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("imemReq",      32'(imemReq),      32'(m_phase == M_FETCH));
    chk("instrValid",   32'(instrValid),   32'(m_phase == M_EXEC));
    chk("halted",       32'(halted),       32'(m_phase == M_HALT));
    chk("imemAddr",     32'(imemAddr),     32'(m_pc));
    chk("pc",           32'(pc),           32'(m_pc));
    chk("pcPlus1",      32'(pcPlus1),      (32'(m_pc) + 1) % 65536);
    chk("opcode",       32'(opcode),       32'(m_ir) >> 11);
    chk("branchFunc",   32'(branchFunc),   (32'(m_ir) >> 8) % 4);
    chk("functionCode", 32'(functionCode), 32'(m_ir) % 4);
    chk("rd",           32'(rd),           (32'(m_ir) >> 8) % 8);
    chk("rm",           32'(rm),           (32'(m_ir) >> 5) % 8);
    chk("rn",           32'(rn),           (32'(m_ir) >> 2) % 8);
    chk("imm8",         32'(imm8),         32'(m_ir) % 256);
`ifdef IFETCH_RETIRE_COUNT_EN
    chk("retireCnt",    32'(retireCnt),    32'(m_cnt));
`endif
  endtask

  // Inputs are changed only at the falling edge, outputs compared there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_req",   32'(imemReq), 0);
    chk("rst_valid", 32'(instrValid), 0);
    chk("rst_halt",  32'(halted), 0);
    chk("rst_pc",    32'(pc), 32'(RESET_PC));

    rst_n = 1'b1;
    tick();
    chk("fetch_req",  32'(imemReq), 1);
    chk("fetch_addr", 32'(imemAddr), 32'h0000);
    imemAck = 1'b0;
    tick(); tick();
    imemAck = 1'b1; imemData = 16'h0800;
    tick();
    chk("exec_valid",  32'(instrValid), 1);
    chk("exec_opcode", 32'(opcode), 32'h01);
    imemAck = 1'b0; pcSel = 2'd0; hlt = 1'b0;
    tick();
    chk("retire_valid", 32'(instrValid), 0);
    chk("retire_pc",    32'(pc), 32'h0001);

    imemAck = 1'b1; imemData = 16'h8123;
    tick();
    chk("label_rd",   32'(rd), 32'h1);
    chk("label_imm8", 32'(imm8), 32'h23);
    imemAck = 1'b0; pcSel = 2'd2;
    tick();
    chk("label_pc", 32'(pc), 32'h0123);

    imemAck = 1'b1; imemData = 16'h0000;
    tick();
    imemAck = 1'b0; pcSel = 2'd1; branchTarget = 16'hFFFF;
    tick();
    chk("branch_pc", 32'(pc), 32'hFFFF);
    imemAck = 1'b1;
    tick();
    imemAck = 1'b0; pcSel = 2'd0;
    tick();
    chk("wrap_pc",   32'(pc), 32'h0000);
    chk("wrap_addr", 32'(imemAddr), 32'h0000);

    imemAck = 1'b1; imemData = 16'hF7FF;
    tick();
    imemAck = 1'b0; pcSel = 2'd3; rmValue = 16'h0BEE;
    tick();
    chk("rm_pc", 32'(pc), 32'h0BEE);

    rst_n = 1'b0;
    tick();
    chk("midrst_pc", 32'(pc), 32'(RESET_PC));
    rst_n = 1'b1; imemAck = 1'b1; imemData = 16'hABCD;
    tick();
    chk("lateack_opcode", 32'(opcode), 0);
    chk("lateack_imm8",   32'(imm8), 0);
    chk("lateack_valid",  32'(instrValid), 0);
    imemAck = 1'b0;
    tick();
    chk("restart_req",  32'(imemReq), 1);
    chk("restart_addr", 32'(imemAddr), 32'(RESET_PC));

    imemAck = 1'b1; imemData = 16'h1234;
    tick();
    imemAck = 1'b0; pcSel = 2'd1; branchTarget = 16'h5555; hlt = 1'b1;
    tick();
    chk("halt_flag", 32'(halted), 1);
    chk("halt_pc",   32'(pc), 32'(RESET_PC));
    hlt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imemAck = 1'($urandom_range(0, 1));
      tick();
      chk("halt_req", 32'(imemReq), 0);
    end

`ifdef IFETCH_RETIRE_COUNT_EN
    rst_n = 1'b0; imemAck = 1'b0; pcSel = 2'd0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      imemAck = 1'b1;
      tick();
      imemAck = 1'b0;
      tick();
    end
    chk("retire_cnt5", 32'(retireCnt), 5);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 49) != 0);
      imemAck      = ($urandom_range(0, 2) == 0);
      imemData     = 16'($urandom);
      pcSel        = 2'($urandom_range(0, 3));
      hlt          = ($urandom_range(0, 19) == 0);
      branchTarget = 16'($urandom);
      rmValue      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
